// File: rtl/im_loader_if.sv
// ============================================================================
// im_loader_if : byte-stream input, IM write port and core-control bundle.
// Revision 1.0
// ============================================================================
`default_nettype none

interface im_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst_f;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_ld;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_rst_f, busy, done, err, words_ld
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, im_we, im_addr, im_wdata, cpu_rst_f, busy, done, err, words_ld
  );
endinterface

`default_nettype wire

// File: rtl/im_loader.sv
// ============================================================================
// im_loader : packs a big-endian byte stream into IM words, holds the core in
//             reset until the whole image is written.  Revision 1.0
// ============================================================================
`default_nettype none

module im_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  wire logic   CLK,
  input  wire logic   RST_F,
  im_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [31:0] C_MAX_WORDS = 32'(MAX_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_count;
  logic [23:0] r_shift;
  logic [1:0]  r_bcnt;
  logic        r_byte_ready;
  logic        r_im_we;
  logic [15:0] r_im_addr;
  logic [31:0] r_im_wdata;
  logic        r_cpu_rst_f;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_words_ld;

  logic        w_acc;
  logic        w_start;
  logic [15:0] w_count_full;
  logic [15:0] w_words_inc;
  logic        w_next_rdy;

  assign w_acc        = bus.byte_valid && r_byte_ready;
  assign w_count_full = {r_count[15:8], bus.byte_in};
  assign w_words_inc  = r_words_ld + 16'd1;
  assign w_start      = bus.start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_next_rdy   = (w_next == S_CNT_HI) || (w_next == S_CNT_LO) || (w_next == S_DATA);

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) w_next = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (w_acc) w_next = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (w_acc) begin
          if (w_count_full == 16'd0)                     w_next = S_DONE;
          else if ({16'd0, w_count_full} > C_MAX_WORDS)  w_next = S_ERR;
          else                                           w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_acc && (r_bcnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = (w_words_inc == r_count) ? S_DONE : S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_count      <= 16'd0;
      r_shift      <= 24'd0;
      r_bcnt       <= 2'd0;
      r_byte_ready <= 1'b0;
      r_im_we      <= 1'b0;
      r_im_addr    <= 16'd0;
      r_im_wdata   <= 32'd0;
      r_cpu_rst_f  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_words_ld   <= 16'd0;
    end else begin
      r_byte_ready <= w_next_rdy;
      r_im_we      <= (w_next == S_WRITE);
      r_busy       <= w_next_rdy || (w_next == S_WRITE);
      r_done       <= (w_next == S_DONE);
      r_err        <= (w_next == S_ERR);
      r_cpu_rst_f  <= (w_next == S_DONE);

      if (w_start) begin
        r_words_ld <= 16'd0;
        r_bcnt     <= 2'd0;
      end

      if ((r_state == S_CNT_HI) && w_acc) r_count[15:8] <= bus.byte_in;
      if ((r_state == S_CNT_LO) && w_acc) r_count[7:0]  <= bus.byte_in;

      if ((r_state == S_DATA) && w_acc) begin
        r_bcnt  <= r_bcnt + 2'd1;
        r_shift <= {r_shift[15:0], bus.byte_in};
        if (r_bcnt == 2'd3) begin
          r_im_wdata <= {r_shift, bus.byte_in};
          r_im_addr  <= BASE_ADDR + r_words_ld;
        end
      end

      if (r_state == S_WRITE) begin
        r_words_ld <= w_words_inc;
        r_bcnt     <= 2'd0;
      end
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.im_we      = r_im_we;
  assign bus.im_addr    = r_im_addr;
  assign bus.im_wdata   = r_im_wdata;
  assign bus.cpu_rst_f  = r_cpu_rst_f;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.words_ld   = r_words_ld;

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
// tb_im_loader : drives two loaders (base 0000 / max 1024, base FFFF / max 3)
//                with one shared byte stream.  Revision 1.0
// ============================================================================
`default_nettype none

module tb_im_loader;

  localparam logic [15:0] BASE_A = 16'h0000;
  localparam logic [15:0] BASE_B = 16'hFFFF;
  localparam int          MAX_A  = 1024;
  localparam int          MAX_B  = 3;

  logic       clk    = 1'b0;
  logic       rst_f  = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] bin    = 8'h00;
  logic       bvalid = 1'b0;

  int errors = 0;
  int checks = 0;

  im_loader_if ifa ();
  im_loader_if ifb ();

  assign ifa.start = start;  assign ifa.byte_in = bin;  assign ifa.byte_valid = bvalid;
  assign ifb.start = start;  assign ifb.byte_in = bin;  assign ifb.byte_valid = bvalid;

  im_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAX_A)) dut_a (.CLK(clk), .RST_F(rst_f), .bus(ifa));
  im_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAX_B)) dut_b (.CLK(clk), .RST_F(rst_f), .bus(ifb));

  always #5 clk = ~clk;

  logic [1:0]  o_done, o_err, o_rst, o_busy, o_ready, o_we;
  logic [15:0] o_wld [2];
  assign o_done  = {ifb.done, ifa.done};
  assign o_err   = {ifb.err, ifa.err};
  assign o_rst   = {ifb.cpu_rst_f, ifa.cpu_rst_f};
  assign o_busy  = {ifb.busy, ifa.busy};
  assign o_ready = {ifb.byte_ready, ifa.byte_ready};
  assign o_we    = {ifb.im_we, ifa.im_we};
  assign o_wld[0] = ifa.words_ld;
  assign o_wld[1] = ifb.words_ld;

  // Expected IM writes {addr, data}, consumed in order by the monitor.
  logic [47:0] exp_a [$];
  logic [47:0] exp_b [$];
  logic [47:0] e;

  logic [31:0] wq [$];
  int          lat;
  logic [1:0]  we_end, rst_after_start, busy_after_start;
  logic [1:0]  e_done, e_err;
  logic [15:0] e_wld [2];

  always @(negedge clk) begin
    if (rst_f) begin
      checks++;
      if (((o_rst & (o_busy | o_err)) != 2'b00) || ((o_we & ~o_busy) != 2'b00)) begin
        errors++;
        $display("FAIL invariant rst_f=%b busy=%b err=%b we=%b", o_rst, o_busy, o_err, o_we);
      end
      if (ifa.im_we) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL write_a unexpected addr=%h data=%h", ifa.im_addr, ifa.im_wdata);
        end else begin
          e = exp_a.pop_front();
          if ({ifa.im_addr, ifa.im_wdata} !== e) begin
            errors++;
            $display("FAIL write_a got %h/%h expected %h/%h", ifa.im_addr, ifa.im_wdata, e[47:32], e[31:0]);
          end
        end
      end
      if (ifb.im_we) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL write_b unexpected addr=%h data=%h", ifb.im_addr, ifb.im_wdata);
        end else begin
          e = exp_b.pop_front();
          if ({ifb.im_addr, ifb.im_wdata} !== e) begin
            errors++;
            $display("FAIL write_b got %h/%h expected %h/%h", ifb.im_addr, ifb.im_wdata, e[47:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; bvalid = 1'b1; bin = 8'hEE;
    @(negedge clk);
    start = 1'b0; bvalid = 1'b0;
    rst_after_start  = o_rst;
    busy_after_start = o_busy;
  endtask

  task automatic drive(input logic [7:0] bq [$], input bit gaps, input int start_at);
    int i    = 0;
    int iter = 0;
    while ((i < bq.size()) && (iter < 4000)) begin
      @(negedge clk);
      start = (iter == start_at);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bvalid = 1'b0;
      end else begin
        bvalid = 1'b1;
        bin    = bq[i];
      end
      if (bvalid && ifa.byte_ready) i++;
      iter++;
    end
    @(negedge clk);
    start = 1'b0; bvalid = 1'b0;
    checks++;
    if (i < bq.size()) begin
      errors++;
      $display("FAIL drive_timeout sent=%0d required=%0d", i, bq.size());
    end
  endtask

  task automatic load(input logic [15:0] cnt, input bit gaps, input int start_at);
    logic [7:0]  bq [$];
    logic [15:0] base;
    int          mx;
    exp_a.delete();
    exp_b.delete();
    bq.push_back(cnt[15:8]);
    bq.push_back(cnt[7:0]);
    for (int d = 0; d < 2; d++) begin
      base      = (d == 0) ? BASE_A : BASE_B;
      mx        = (d == 0) ? MAX_A : MAX_B;
      e_done[d] = (cnt == 16'd0) || (int'(cnt) <= mx);
      e_err[d]  = !e_done[d];
      e_wld[d]  = e_done[d] ? cnt : 16'd0;
      if (e_done[d]) begin
        for (int w = 0; w < int'(cnt); w++) begin
          if (d == 0) exp_a.push_back({base + 16'(w), wq[w]});
          else        exp_b.push_back({base + 16'(w), wq[w]});
        end
      end
    end
    if (e_done[0]) begin
      for (int w = 0; w < int'(cnt); w++) begin
        bq.push_back(wq[w][31:24]); bq.push_back(wq[w][23:16]);
        bq.push_back(wq[w][15:8]);  bq.push_back(wq[w][7:0]);
      end
    end
    pulse_start();
    drive(bq, gaps, start_at);
    we_end = o_we;
    lat    = 0;
    while (!(&(o_done | o_err)) && (lat < 50)) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!(&(o_done | o_err))) begin
      errors++;
      $display("FAIL load_timeout done=%b err=%b", o_done, o_err);
    end
  endtask

  task automatic fill_words(input int n);
    wq.delete();
    for (int w = 0; w < n; w++) wq.push_back($urandom);
  endtask

  task automatic test_reset();
    logic [7:0] bq [$];
    repeat (2) @(negedge clk);
    checks++;
    if ({o_done, o_err, o_rst, o_busy, o_ready, o_we, o_wld[0], o_wld[1],
         ifa.im_addr, ifa.im_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_init done=%b err=%b rst=%b busy=%b rdy=%b we=%b addr=%h data=%h, required all 0",
               o_done, o_err, o_rst, o_busy, o_ready, o_we, ifa.im_addr, ifa.im_wdata);
    end
    rst_f = 1'b1;
    bq.push_back(8'h00); bq.push_back(8'h02); bq.push_back(8'h11); bq.push_back(8'h22);
    pulse_start();
    drive(bq, 1'b0, -1);
    checks++;
    if ((o_busy !== 2'b11) || (o_ready !== 2'b11)) begin
      errors++;
      $display("FAIL reset_middata busy=%b rdy=%b required 11/11", o_busy, o_ready);
    end
    #2 rst_f = 1'b0;
    #1;
    checks++;
    if ({o_done, o_err, o_rst, o_busy, o_ready, o_we, o_wld[0], o_wld[1]} !== '0) begin
      errors++;
      $display("FAIL reset_async done=%b err=%b rst=%b busy=%b rdy=%b we=%b, required all 0",
               o_done, o_err, o_rst, o_busy, o_ready, o_we);
    end
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_done, o_rst, o_busy, o_ready, o_we} !== '0) begin
      errors++;
      $display("FAIL reset_release done=%b rst=%b busy=%b rdy=%b we=%b, required all 0",
               o_done, o_rst, o_busy, o_ready, o_we);
    end
  endtask

  task automatic test_two_word();
    wq.delete();
    wq.push_back(32'h12345678);
    wq.push_back(32'h9ABCDEF0);
    load(16'd2, 1'b0, -1);
    checks++;
    if ((lat != 1) || (we_end !== 2'b11)) begin
      errors++;
      $display("FAIL two_word_latency lat=%0d we=%b required lat=1 we=11", lat, we_end);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_done[d], o_err[d], o_rst[d], o_busy[d], o_ready[d]} !== {e_done[d], e_err[d], e_done[d], 2'b00} ||
          (o_wld[d] !== e_wld[d]) || ((d == 0) ? exp_a.size() : exp_b.size()) != 0) begin
        errors++;
        $display("FAIL two_word dut%0d done/err/rst/busy/rdy=%b%b%b%b%b wld=%0d required %b%b%b00 wld=%0d",
                 d, o_done[d], o_err[d], o_rst[d], o_busy[d], o_ready[d], o_wld[d], e_done[d], e_err[d], e_done[d], e_wld[d]);
      end
    end
    bvalid = 1'b1;
    repeat (3) @(negedge clk);
    bvalid = 1'b0;
    checks++;
    if ((o_ready !== 2'b00) || (o_done !== 2'b11)) begin
      errors++;
      $display("FAIL two_word_hold rdy=%b done=%b required 00/11", o_ready, o_done);
    end
  endtask

  task automatic test_zero_count();
    wq.delete();
    load(16'd0, 1'b0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_done[d], o_err[d], o_rst[d], o_busy[d]} !== 4'b1010 || (o_wld[d] !== 16'd0)) begin
        errors++;
        $display("FAIL zero_count dut%0d done/err/rst/busy=%b%b%b%b wld=%0d required 1010 wld=0",
                 d, o_done[d], o_err[d], o_rst[d], o_busy[d], o_wld[d]);
      end
    end
  endtask

  task automatic test_oversize();
    wq.delete();
    load(16'h0401, 1'b0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_done[d], o_err[d], o_rst[d], o_busy[d]} !== 4'b0100) begin
        errors++;
        $display("FAIL oversize dut%0d done/err/rst/busy=%b%b%b%b required 0100",
                 d, o_done[d], o_err[d], o_rst[d], o_busy[d]);
      end
    end
    fill_words(1);
    load(16'd1, 1'b0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_done[d], o_err[d], o_rst[d]} !== 3'b101 || (o_wld[d] !== 16'd1) ||
          ((d == 0) ? exp_a.size() : exp_b.size()) != 0) begin
        errors++;
        $display("FAIL oversize_recover dut%0d done/err/rst=%b%b%b wld=%0d required 101 wld=1",
                 d, o_done[d], o_err[d], o_rst[d], o_wld[d]);
      end
    end
  endtask

  task automatic test_gapped();
    fill_words(2);
    load(16'd2, 1'b1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_done[d], o_err[d], o_rst[d]} !== 3'b101 || (o_wld[d] !== 16'd2) ||
          ((d == 0) ? exp_a.size() : exp_b.size()) != 0) begin
        errors++;
        $display("FAIL gapped dut%0d done/err/rst=%b%b%b wld=%0d required 101 wld=2",
                 d, o_done[d], o_err[d], o_rst[d], o_wld[d]);
      end
    end
  endtask

  task automatic test_reload();
    fill_words(3);
    load(16'd3, 1'b1, 5);
    checks++;
    if ((rst_after_start !== 2'b00) || (busy_after_start !== 2'b11)) begin
      errors++;
      $display("FAIL reload_start rst=%b busy=%b required 00/11", rst_after_start, busy_after_start);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_done[d], o_err[d], o_rst[d]} !== 3'b101 || (o_wld[d] !== 16'd3) ||
          ((d == 0) ? exp_a.size() : exp_b.size()) != 0) begin
        errors++;
        $display("FAIL reload dut%0d done/err/rst=%b%b%b wld=%0d required 101 wld=3",
                 d, o_done[d], o_err[d], o_rst[d], o_wld[d]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] cnt;
    for (int it = 0; it < 10; it++) begin
      cnt = (it == 0) ? 16'd4 : (it == 1) ? 16'd3 : 16'($urandom_range(0, 5));
      fill_words(5);
      load(cnt, 1'($urandom_range(0, 1)), -1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({o_done[d], o_err[d], o_rst[d], o_busy[d]} !== {e_done[d], e_err[d], e_done[d], 1'b0} ||
            (o_wld[d] !== e_wld[d]) || ((d == 0) ? exp_a.size() : exp_b.size()) != 0) begin
          errors++;
          $display("FAIL random cnt=%0d dut%0d done/err/rst/busy=%b%b%b%b wld=%0d required %b%b%b0 wld=%0d",
                   cnt, d, o_done[d], o_err[d], o_rst[d], o_busy[d], o_wld[d], e_done[d], e_err[d], e_done[d], e_wld[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_zero_count();
    test_oversize();
    test_gapped();
    test_reload();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
